// File: rtl/sub64_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sub64_seq
//  Description : Multi-cycle two's-complement subtractor (A - B = A + ~B + 1),
//                CHUNK bits per cycle, with Y86 subq flags and unsigned borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub64_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             overflow,
    output logic             zf,
    output logic             sf,
    output logic             borrow
);

    localparam int NCHUNK  = WIDTH / CHUNK;
    localparam int c_cnt_w = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sub64_seq: CHUNK must divide WIDTH");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_work;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_count;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_of;
    logic               r_zf;
    logic               r_sf;
    logic               r_borrow;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_sum;
    logic [WIDTH-1:0]   w_work_nxt;
    logic               w_last;

    // Mux-based chunk select keeps the per-cycle path to one CHUNK-wide adder.
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_count == c_cnt_w'(i)) begin
                w_a_chunk = r_opa[i*CHUNK +: CHUNK];
                w_b_chunk = r_opb[i*CHUNK +: CHUNK];
            end
        end
        w_sum      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_work_nxt = r_work;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_count == c_cnt_w'(i)) begin
                w_work_nxt[i*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
            end
        end
        w_last     = (r_count == c_cnt_w'(NCHUNK - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (w_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = start ? c_run : c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_idle;
            r_opa    <= '0;
            r_opb    <= '0;
            r_work   <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_of     <= 1'b0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_opa   <= A;
                        r_opb   <= ~B;
                        r_carry <= 1'b1;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_run: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_sum[CHUNK];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_diff   <= w_work_nxt;
                        r_borrow <= ~w_sum[CHUNK];
                        r_sf     <= w_work_nxt[WIDTH-1];
                        r_zf     <= (w_work_nxt == '0);
                        // opB holds ~B, so equal stored MSBs mean A and B differ in sign
                        r_of     <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                                    (w_work_nxt[WIDTH-1] != r_opa[WIDTH-1]);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign overflow = r_of;
    assign zf       = r_zf;
    assign sf       = r_sf;
    assign borrow   = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_sub64_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub64_seq
//  Description : Self-checking bench for sub64_seq: vector table, handshake
//                corner cases, reset abort, chunk-size latency, random model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub64_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;

    logic        busy, done, overflow, zf, sf, borrow;
    logic [63:0] diff;
    logic        busy8, done8, of8, zf8, sf8, bw8;
    logic [63:0] diff8;
    logic        busy64, done64, of64, zf64, sf64, bw64;
    logic [63:0] diff64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub64_seq dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .diff(diff), .overflow(overflow),
        .zf(zf), .sf(sf), .borrow(borrow)
    );

    sub64_seq #(.WIDTH(64), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy8), .done(done8), .diff(diff8), .overflow(of8),
        .zf(zf8), .sf(sf8), .borrow(bw8)
    );

    sub64_seq #(.WIDTH(64), .CHUNK(64)) dut64 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy64), .done(done64), .diff(diff64), .overflow(of64),
        .zf(zf64), .sf(sf64), .borrow(bw64)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic        of;
        logic        zf;
        logic        sf;
        logic        bw;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
    endtask

    // Called with start already high; returns at the negedge where done is seen.
    task automatic wait_done(input logic chk_hold, input logic [63:0] hold_val,
                             output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                A = {$urandom, $urandom};
                B = {$urandom, $urandom};
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            if (chk_hold) chk("hold_diff", diff, hold_val);
        end
    endtask

    vec_t        vecs[10];
    int          lat, bcnt, dcount, lat8, lat64;
    logic [63:0] ra, rb, rd;

    initial begin
        vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{64'd10, 64'd20, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{64'h0000_0000_0001_0000, 64'd1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_diff", diff, 64'd0);
        chk("reset_flags", {60'd0, overflow, zf, sf, borrow}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(1'b0, 64'd0, lat, bcnt);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd4);
            chk($sformatf("v%0d_diff", i), diff, vecs[i].d);
            chk($sformatf("v%0d_of", i), {63'd0, overflow}, {63'd0, vecs[i].of});
            chk($sformatf("v%0d_zf", i), {63'd0, zf}, {63'd0, vecs[i].zf});
            chk($sformatf("v%0d_sf", i), {63'd0, sf}, {63'd0, vecs[i].sf});
            chk($sformatf("v%0d_borrow", i), {63'd0, borrow}, {63'd0, vecs[i].bw});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // start pulsed mid-RUN must be ignored
        launch(64'd5, 64'd3);
        @(posedge clk);
        dcount = 0;
        rd = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                A = 64'd100;
                B = 64'd1;
            end
            if (done) begin
                dcount++;
                if (dcount == 1) rd = diff;
            end
        end
        start = 1'b0;
        chk("ignore_done_count", 64'(dcount), 64'd1);
        chk("ignore_diff", rd, 64'd2);

        // back-to-back: start held in DONE cycle, first result held meanwhile
        launch(64'd1000, 64'd1);
        wait_done(1'b0, 64'd0, lat, bcnt);
        chk("b2b_first_diff", diff, 64'd999);
        A = 64'd10;
        B = 64'd20;
        start = 1'b1;
        wait_done(1'b1, 64'd999, lat, bcnt);
        chk("b2b_latency", 64'(lat), 64'd5);
        chk("b2b_diff", diff, 64'hFFFF_FFFF_FFFF_FFF6);
        chk("b2b_sf_borrow", {62'd0, sf, borrow}, 64'd3);

        // reset on the second RUN cycle aborts the operation
        launch(64'd7, 64'd2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_run_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_run_diff", diff, 64'd0);
        chk("rst_run_flags", {60'd0, overflow, zf, sf, borrow}, 64'd0);
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_run_no_done", 64'(dcount), 64'd0);
        launch(64'd100, 64'd1);
        wait_done(1'b0, 64'd0, lat, bcnt);
        chk("after_rst_latency", 64'(lat), 64'd5);
        chk("after_rst_diff", diff, 64'd99);

        // latency for CHUNK=8 and CHUNK=64 from a clean reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        launch(64'd7, 64'd2);
        @(posedge clk);
        lat8 = 0;
        lat64 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done8 && lat8 == 0) lat8 = k;
            if (done64 && lat64 == 0) lat64 = k;
        end
        chk("chunk8_latency", 64'(lat8), 64'd9);
        chk("chunk64_latency", 64'(lat64), 64'd2);
        chk("chunk8_diff", diff8, 64'd5);
        chk("chunk64_diff", diff64, 64'd5);

        // random pairs against a behavioural model
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = (i % 8 == 0) ? ra : {$urandom, $urandom};
            launch(ra, rb);
            wait_done(1'b0, 64'd0, lat, bcnt);
            rd = ra - rb;
            chk("rand_diff", diff, rd);
            chk("rand_flags", {60'd0, overflow, zf, sf, borrow},
                {60'd0, (ra[63] != rb[63]) && (rd[63] != ra[63]), rd == 64'd0, rd[63], ra < rb});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
